// File: rtl/data_delay_vld_if.sv
// Bus bundle for data_delay_vld: stall/flush controls, input beat and the
// delayed output beat with its occupancy status.
interface data_delay_vld_if #(
  parameter int DATA_BW = 10,
  parameter int STAGE   = 2
);
  localparam int CNT_BW = (STAGE < 1) ? 1 : $clog2(STAGE + 1);

  logic               i_en;
  logic               i_flush;
  logic               i_valid;
  logic [DATA_BW-1:0] i_data;
  logic               o_valid;
  logic [DATA_BW-1:0] o_data;
  logic [CNT_BW-1:0]  o_count;
  logic               o_empty;

  modport master (
    output i_en, i_flush, i_valid, i_data,
    input  o_valid, o_data, o_count, o_empty
  );

  modport slave (
    input  i_en, i_flush, i_valid, i_data,
    output o_valid, o_data, o_count, o_empty
  );
endinterface

// File: rtl/data_delay_vld.sv
// Valid-tagged, stallable fixed-latency delay line with synchronous flush
// and an in-flight beat count; STAGE=0 degenerates to a combinational wire.
module data_delay_vld #(
  parameter int DATA_BW   = 10,
  parameter int STAGE     = 2,
  parameter bit DATA_GATE = 1'b1
) (
  input logic             i_clk,
  input logic             i_rst_n,
  data_delay_vld_if.slave bus
);
  localparam int CNT_BW = (STAGE < 1) ? 1 : $clog2(STAGE + 1);

  generate
    if (STAGE == 0) begin : g_pass
      logic unused_s;
      assign unused_s    = ^{i_clk, i_rst_n, bus.i_en, bus.i_flush};
      assign bus.o_valid = bus.i_valid;
      assign bus.o_data  = bus.i_data;
      assign bus.o_count = {CNT_BW{1'b0}};
      assign bus.o_empty = 1'b1;
    end else begin : g_pipe
      logic [STAGE:1]     vld_q, vld_d;
      logic [DATA_BW-1:0] data_q [1:STAGE];
      logic [DATA_BW-1:0] data_d [1:STAGE];
      logic [CNT_BW-1:0]  cnt_q, cnt_d;
      logic               empty_q, empty_d;
      logic [STAGE-1:0]   vld_s;
      logic [DATA_BW-1:0] data_s [0:STAGE-1];

      // Stage i's source: the input port for stage 1, register i-1 otherwise
      always_comb begin
        vld_s     = {STAGE{1'b0}};
        vld_s[0]  = bus.i_valid;
        data_s[0] = bus.i_data;
        for (int i = 1; i < STAGE; i++) begin
          vld_s[i]  = vld_q[i];
          data_s[i] = data_q[i];
        end
      end

      always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (bus.i_flush) begin
          vld_d = {STAGE{1'b0}};
          cnt_d = {CNT_BW{1'b0}};
        end else if (bus.i_en) begin
          for (int i = 1; i <= STAGE; i++) begin
            vld_d[i] = vld_s[i-1];
            if (!DATA_GATE || vld_s[i-1]) begin
              data_d[i] = data_s[i-1];
            end else begin
              data_d[i] = data_q[i];
            end
          end
          // A beat leaving the last stage can only exist if cnt_q >= 1
          cnt_d = cnt_q + CNT_BW'(bus.i_valid) - CNT_BW'(vld_q[STAGE]);
        end else begin
          vld_d = vld_q;
          cnt_d = cnt_q;
        end
        empty_d = (cnt_d == {CNT_BW{1'b0}});
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          vld_q   <= {STAGE{1'b0}};
          cnt_q   <= {CNT_BW{1'b0}};
          empty_q <= 1'b1;
          for (int i = 1; i <= STAGE; i++) begin
            data_q[i] <= {DATA_BW{1'b0}};
          end
        end else begin
          vld_q   <= vld_d;
          cnt_q   <= cnt_d;
          empty_q <= empty_d;
          for (int i = 1; i <= STAGE; i++) begin
            data_q[i] <= data_d[i];
          end
        end
      end

      assign bus.o_valid = vld_q[STAGE];
      assign bus.o_data  = data_q[STAGE];
      assign bus.o_count = cnt_q;
      assign bus.o_empty = empty_q;
    end
  endgenerate
endmodule
